ps2_kb_receiver: RTL and testbench
==================================

# ps2_kb_receiver

PS/2 keyboard front end feeding the keyboard control stage. Synchronises and de-glitches the raw PS/2 clock/data lines, deframes 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop), and shifts each valid scan byte into a 16-bit two-byte history `KBBuffer` consumed downstream (break prefix `F0` lands in `[15:8]`, key code in `[7:0]`). Framing, parity and timeout errors are flagged and the history is left untouched.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples required before filtered PS2 clock changes.
- `TIMEOUT_CYCLES`, 200000: idle cycles, 2 ms at 100 MHz, allowed between falling edges inside a frame.
- `CLK`  in  1  system clock; one clock domain.
- `RESET`  in  1  asynchronous, active-high reset.
- `PS2_CLK`  in  1  raw keyboard clock, asynchronous.
- `PS2_DATA`  in  1  raw keyboard data, asynchronous.
- `KBBuffer`  out  16  `{previous byte, latest byte}`.
- `ByteReady`  out  1  one-cycle pulse when `KBBuffer` updates.
- `FrameError`  out  1  one-cycle pulse on discarded frame.
- `BitCount`  out  4  data bits received in current frame; debug.

## Operation
- Both raw inputs pass a 2-FF synchroniser.
- Clock filter: counter restarts on every change of the synchronised clock. Filtered clock takes the new value once it has been stable for `FILTER_LEN` cycles. Data is not filtered. Data is sampled on the cycle the filtered clock falls.
- `fall` is a single-cycle strobe on a 1->0 transition of the filtered clock.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: `fall` with data=0 -> DATA, `BitCount`<=0. `fall` with data=1 -> stay IDLE, no error.
  - DATA: on each `fall`, shift register <= `{data, sr[7:1]}` and `BitCount`++. After the 8th bit -> PARITY.
  - PARITY: on `fall`, latch the parity bit -> STOP.
  - STOP: on `fall`, valid iff data=1 and XOR(8 data bits, parity)=1.
    - Valid: `KBBuffer` <= `{KBBuffer[7:0], sr}` and `ByteReady`=1.
    - Invalid: `FrameError`=1 and `KBBuffer` unchanged.
    - Either way -> IDLE.
- Timeout: counter clears on every `fall` and while in IDLE. It counts in the other states. On reaching `TIMEOUT_CYCLES-1`: -> IDLE, `FrameError`=1, partial byte dropped.
- Timeout and `fall` in the same cycle: `fall` wins and the counter clears.
- `ByteReady` and `FrameError` are never asserted together.
- No interpretation of scan codes: `E0`, `F0` and typematic repeats are all shifted in as plain bytes.

## Timing
- Reset values:
  - `KBBuffer`=16'h0000, `ByteReady`=0, `FrameError`=0, `BitCount`=0.
  - State IDLE, filtered clock=1, shift register=0, all counters=0.
- Reset mid-frame aborts the frame; no pulse after release.
- Edge latency: raw `PS2_CLK` fall to `fall` strobe = 2 synchroniser cycles + `FILTER_LEN` cycles + 1.
- Stop-bit `fall` in cycle N -> `KBBuffer` update and `ByteReady` high in cycle N+1, for exactly one cycle.
- Timeout detection in cycle N -> `FrameError` in cycle N+1.
- Filter counter width `$clog2(FILTER_LEN+1)`; timeout counter width `$clog2(TIMEOUT_CYCLES+1)`. Neither counter wraps: each saturates until cleared.
- Minimum PS/2 half-period (30 us) far exceeds filter latency, so back-to-back frames need no idle gap beyond the stop bit.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - `PS2_DATA_BITS`=8.
  - Break code `8'hF0` and extended code `8'hE0` constants, shared with the downstream control stage.
- Sub-module `ps2_input_filter`: synchroniser plus clock glitch filter; outputs filtered clock, synchronised data and the `fall` strobe.
- Top: FSM, shift register, parity, timeout counter, history register.

## Test plan
- Valid frame `1C`: bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1 -> one `ByteReady`, `KBBuffer`=16'h001C.
- Break sequence `F0` then `1C` -> `KBBuffer`=16'hF01C after the second pulse; exactly two `ByteReady` pulses.
- Frame `16` with wrong parity -> one `FrameError`, `KBBuffer` unchanged, no `ByteReady`; a following valid `45` gives `KBBuffer`={old[7:0],45}.
- Stop bit 0 on otherwise valid frame -> `FrameError`; stall clock after 4 data bits for `TIMEOUT_CYCLES` -> `FrameError`, IDLE; the next valid frame is received correctly.
- Glitch pulses on `PS2_CLK` shorter than `FILTER_LEN` cycles between edges -> no extra bits; byte decodes correctly.
- Assert `RESET` during the DATA state -> all outputs 0 immediately; after release a full valid frame `5A` yields `KBBuffer`=16'h005A.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: receiver FSM states and scan-code constants
// used by both the receiver and the downstream keyboard control stage.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronises raw PS/2 clock/data and de-glitches the clock; emits a one-cycle
// strobe on each filtered falling edge together with the data sampled on it.
module ps2_input_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_filt_o,
  output logic data_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             fall_q, fall_d;
  logic             data_q, data_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      cnt_q       <= '0;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      fall_q      <= fall_d;
      data_q      <= data_d;
    end
  end

  // Any return of the synchronised clock to the filtered level restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (clk_sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      filt_d = clk_sync_q[1];
      cnt_d  = '0;
    end else if (cnt_q != CNT_W'(FILTER_LEN)) begin
      cnt_d = cnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
    data_d = data_sync_q[1];
  end

  assign clk_filt_o = filt_q;
  assign data_o     = data_q;
  assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_kb_receiver.sv
// PS/2 device-to-host deframer: start, 8 data bits LSB first, odd parity, stop.
// Valid bytes shift into a two-byte history; bad or stalled frames pulse FrameError.
module ps2_kb_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [15:0] KBBuffer,
  output logic        ByteReady,
  output logic        FrameError,
  output logic [3:0]  BitCount
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_filt, data_s, fall_raw, fall;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .ps2_clk_i  (PS2_CLK),
    .ps2_data_i (PS2_DATA),
    .clk_filt_o (clk_filt),
    .data_o     (data_s),
    .fall_o     (fall_raw)
  );

  assign fall = fall_raw & ~clk_filt;

  ps2_state_e               state_q, state_d;
  logic [PS2_DATA_BITS-1:0] sr_q, sr_d;
  logic                     par_q, par_d;
  logic [3:0]               bitcnt_q, bitcnt_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [15:0]              kb_q, kb_d;
  logic                     rdy_q, rdy_d;
  logic                     ferr_q, ferr_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      tmo_q    <= '0;
      kb_q     <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      bitcnt_q <= bitcnt_d;
      tmo_q    <= tmo_d;
      kb_q     <= kb_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    tmo_d    = tmo_q;
    kb_d     = kb_q;
    rdy_d    = 1'b0;
    ferr_d   = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall && !data_s) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          sr_d     = {data_s, sr_q[PS2_DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (data_s && (^{sr_q, par_q})) begin
            kb_d  = {kb_q[7:0], sr_q};
            rdy_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A falling edge in the same cycle always takes precedence over the timeout.
    if (state_q != ST_IDLE && !fall && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      rdy_d   = 1'b0;
    end
  end

  assign KBBuffer   = kb_q;
  assign ByteReady  = rdy_q;
  assign FrameError = ferr_q;
  assign BitCount   = bitcnt_q;

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// Directed and randomized PS/2 frames checked against a byte-level history model.
module tb_ps2_kb_receiver;

  localparam int unsigned FL   = 8;
  localparam int unsigned TMO  = 3000;
  localparam int unsigned HALF = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2c;
  logic        ps2d;
  logic [15:0] KBBuffer;
  logic        ByteReady;
  logic        FrameError;
  logic [3:0]  BitCount;

  always #5 clk = ~clk;

  ps2_kb_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .PS2_CLK    (ps2c),
    .PS2_DATA   (ps2d),
    .KBBuffer   (KBBuffer),
    .ByteReady  (ByteReady),
    .FrameError (FrameError),
    .BitCount   (BitCount)
  );

  int          checks = 0;
  int          errors = 0;
  int          br_cnt = 0;
  int          fe_cnt = 0;
  logic [15:0] exp_kb;
  logic [15:0] prev_kb = 16'h0;
  logic        prev_br = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: exclusive, single-cycle pulses; history only moves with ByteReady.
  always @(negedge clk) begin
    if (rst) begin
      prev_kb = 16'h0;
      prev_br = 1'b0;
    end else begin
      if (ByteReady)  br_cnt++;
      if (FrameError) fe_cnt++;
      if (ByteReady || FrameError || KBBuffer !== prev_kb) begin
        checks++;
        assert (!(ByteReady && FrameError) && !(ByteReady && prev_br) &&
                (KBBuffer === prev_kb || ByteReady)) else begin
          errors++;
          $error("FAIL pulse_rules observed=br%0b fe%0b kb%h expected=exclusive single pulse kb%h",
                 ByteReady, FrameError, KBBuffer, prev_kb);
        end
      end
      prev_kb = KBBuffer;
      prev_br = ByteReady;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Frame bits in transmission order; kind 1 = bad parity, kind 2 = bad stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
    logic p;
    p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (kind == 1) p = ~p;
    return {(kind == 2) ? 1'b0 : 1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ps2d = f[i];
      wait_cycles(HALF / 2);
      if (glitch) begin
        ps2c = 1'b0; wait_cycles(3); ps2c = 1'b1;
      end
      wait_cycles(HALF / 2);
      ps2c = 1'b0;
      wait_cycles(HALF / 2);
      if (glitch) begin
        ps2c = 1'b1; wait_cycles(3); ps2c = 1'b0;
      end
      wait_cycles(HALF / 2);
      ps2c = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input int kind, input bit glitch, input string tag);
    int br0, fe0;
    br0 = br_cnt;
    fe0 = fe_cnt;
    send_bits(make_frame(b, kind), 11, glitch);
    ps2d = 1'b1;
    wait_cycles(HALF);
    @(negedge clk);
    if (kind == 0) exp_kb = {exp_kb[7:0], b};
    chk({tag, "_ready"}, 32'(br_cnt - br0), (kind == 0) ? 32'd1 : 32'd0);
    chk({tag, "_ferr"},  32'(fe_cnt - fe0), (kind == 0) ? 32'd0 : 32'd1);
    chk({tag, "_kb"},    32'(KBBuffer), 32'(exp_kb));
  endtask

  initial begin
    int br0, fe0, n;
    logic [7:0] rb;
    int kind;
    rst    = 1'b1;
    ps2c   = 1'b1;
    ps2d   = 1'b1;
    exp_kb = 16'h0;
    wait_cycles(5);
    @(negedge clk);
    chk("reset_kb", 32'(KBBuffer), 32'h0);
    chk("reset_ready", 32'(ByteReady), 32'h0);
    chk("reset_ferr", 32'(FrameError), 32'h0);
    chk("reset_bitcnt", 32'(BitCount), 32'h0);
    rst = 1'b0;
    wait_cycles(20);

    run_frame(8'h1C, 0, 1'b0, "frame_1c");
    run_frame(8'hF0, 0, 1'b0, "break_f0");
    run_frame(8'h1C, 0, 1'b0, "break_1c");
    chk("break_history", 32'(KBBuffer), 32'hF01C);
    run_frame(8'h16, 1, 1'b0, "bad_parity");
    run_frame(8'h45, 0, 1'b0, "after_parity");
    run_frame(8'h29, 2, 1'b0, "bad_stop");

    // Stall after four data bits until the frame times out.
    br0 = br_cnt;
    fe0 = fe_cnt;
    send_bits(make_frame(8'h6B, 0), 5, 1'b0);
    wait_cycles(100);
    @(negedge clk);
    chk("stall_bitcnt", 32'(BitCount), 32'd4);
    n = 0;
    while (fe_cnt == fe0 && n < int'(TMO) + 500) begin
      @(posedge clk);
      n++;
    end
    ps2d = 1'b1;
    wait_cycles(10);
    @(negedge clk);
    chk("timeout_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("timeout_ready", 32'(br_cnt - br0), 32'd0);
    chk("timeout_kb", 32'(KBBuffer), 32'(exp_kb));
    run_frame(8'h33, 0, 1'b0, "after_timeout");

    run_frame(8'hA7, 0, 1'b1, "glitch_a7");
    run_frame(8'hE0, 0, 1'b1, "glitch_e0");

    // Reset in the middle of the data bits.
    send_bits(make_frame(8'h77, 0), 4, 1'b0);
    wait_cycles(30);
    @(negedge clk);
    chk("middata_bitcnt", 32'(BitCount), 32'd3);
    rst = 1'b1;
    #1;
    chk("midreset_kb", 32'(KBBuffer), 32'h0);
    chk("midreset_bitcnt", 32'(BitCount), 32'h0);
    chk("midreset_ready", 32'(ByteReady), 32'h0);
    chk("midreset_ferr", 32'(FrameError), 32'h0);
    exp_kb = 16'h0;
    wait_cycles(5);
    ps2d = 1'b1;
    rst  = 1'b0;
    br0 = br_cnt;
    fe0 = fe_cnt;
    wait_cycles(TMO + 100);
    @(negedge clk);
    chk("postreset_pulses", 32'((br_cnt - br0) + (fe_cnt - fe0)), 32'd0);
    run_frame(8'h5A, 0, 1'b0, "frame_5a");
    chk("frame_5a_history", 32'(KBBuffer), 32'h005A);

    for (int i = 0; i < 24; i++) begin
      rb   = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      if (kind == 3) kind = 0;
      run_frame(rb, kind, bit'($urandom_range(0, 1)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
